// File: rtl/ysyx_22040931_ifu_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22040931_ifu_pkg
// Shared definitions for the instruction fetch unit:
//   - ysyx_22040931_PC_BUS   : program counter width
//   - ysyx_22040931_INST_BUS : instruction width
//   - ysyx_22040931_NOP      : instruction offered for a misaligned PC
//   - ifu_state_e            : fetch FSM state encodings
//   - select_word()          : picks the 32-bit half of a doubleword
// ----------------------------------------------------------------------------
package ysyx_22040931_ifu_pkg;

   localparam int ysyx_22040931_PC_BUS   = 64;
   localparam int ysyx_22040931_INST_BUS = 32;
   localparam int ysyx_22040931_DATA_BUS = 2 * ysyx_22040931_INST_BUS;

   localparam logic [ysyx_22040931_INST_BUS-1:0] ysyx_22040931_NOP = 32'h0000_0013;

   // DROP waits for the response of a request that was already granted when a
   // redirect arrived, so the stale data can never be mistaken for a new fetch.
   typedef enum logic [2:0] {
      IFU_IDLE = 3'd0,
      IFU_REQ  = 3'd1,
      IFU_WAIT = 3'd2,
      IFU_HOLD = 3'd3,
      IFU_DROP = 3'd4
   } ifu_state_e;

   // Memory returns a whole doubleword; address bit 2 selects the upper word.
   function automatic logic [ysyx_22040931_INST_BUS-1:0] select_word(
      input logic [ysyx_22040931_DATA_BUS-1:0] rdata,
      input logic                              upper
   );
      return upper ? rdata[ysyx_22040931_DATA_BUS-1:ysyx_22040931_INST_BUS]
                   : rdata[ysyx_22040931_INST_BUS-1:0];
   endfunction

endpackage

// File: rtl/ysyx_22040931_ifu.sv
// ----------------------------------------------------------------------------
// ysyx_22040931_ifu
// Instruction fetch unit. Accepts a PC from the PC stage, issues one
// doubleword read to instruction memory, and offers the selected 32-bit
// instruction to decode with a valid/ready handshake. Misaligned PCs skip the
// memory access and are offered as a NOP flagged with id_misalign.
//
// Ports:
//   clock, reset           : clock, synchronous active-high reset
//   flush                  : redirect, kills the fetch in flight
//   pc_valid, pc, if_ready : PC handshake from the PC stage
//   mem_req, mem_addr      : instruction memory request (doubleword aligned)
//   mem_gnt                : memory accepted the request
//   mem_rvalid, mem_rdata  : memory read response
//   id_valid, id_ready     : handshake toward decode
//   id_pc, id_instr        : offered PC and instruction
//   id_misalign            : offered PC had pc[1:0] != 0
// ----------------------------------------------------------------------------
module ysyx_22040931_ifu
   import ysyx_22040931_ifu_pkg::*;
(
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              flush,
   input  logic                              pc_valid,
   input  logic [ysyx_22040931_PC_BUS-1:0]   pc,
   output logic                              if_ready,
   output logic                              mem_req,
   output logic [ysyx_22040931_PC_BUS-1:0]   mem_addr,
   input  logic                              mem_gnt,
   input  logic                              mem_rvalid,
   input  logic [ysyx_22040931_DATA_BUS-1:0] mem_rdata,
   output logic                              id_valid,
   input  logic                              id_ready,
   output logic [ysyx_22040931_PC_BUS-1:0]   id_pc,
   output logic [ysyx_22040931_INST_BUS-1:0] id_instr,
   output logic                              id_misalign
);

   ifu_state_e                        state_q, state_d;
   logic [ysyx_22040931_PC_BUS-1:0]   pc_q, pc_d;
   logic [ysyx_22040931_INST_BUS-1:0] instr_q, instr_d;
   logic                              misalign_q, misalign_d;
   logic                              accept;

   // Handshake and memory-side outputs are decoded straight from the state.
   // mem_req deliberately ignores flush: a flush in REQ is resolved by looking
   // at mem_gnt, so the request must stay stable for the memory in that cycle.
   always_comb begin
      if_ready = ~flush & ((state_q == IFU_IDLE) | ((state_q == IFU_HOLD) & id_ready));
      accept   = pc_valid & if_ready;
      mem_req  = (state_q == IFU_REQ);
      mem_addr = {pc_q[ysyx_22040931_PC_BUS-1:3], 3'b000};
      id_valid = (state_q == IFU_HOLD) & ~flush;
      id_pc    = pc_q;
      id_instr = instr_q;
      id_misalign = misalign_q;
   end

   // Next-state logic. Flush is handled first so it wins over pc_valid and
   // id_ready. A granted request whose response has not yet arrived must go
   // through DROP to swallow that response; otherwise the unit idles at once.
   // Accepting a PC in HOLD gives back-to-back throughput toward decode.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      misalign_d = misalign_q;

      if (flush) begin
         case (state_q)
            IFU_REQ:  state_d = mem_gnt    ? IFU_DROP : IFU_IDLE;
            IFU_WAIT: state_d = mem_rvalid ? IFU_IDLE : IFU_DROP;
            IFU_DROP: state_d = mem_rvalid ? IFU_IDLE : IFU_DROP;
            default:  state_d = IFU_IDLE;
         endcase
      end else begin
         case (state_q)
            IFU_IDLE, IFU_HOLD: begin
               if (accept) begin
                  pc_d = pc;
                  if (pc[1:0] == 2'b00) begin
                     state_d = IFU_REQ;
                  end else begin
                     state_d    = IFU_HOLD;
                     instr_d    = ysyx_22040931_NOP;
                     misalign_d = 1'b1;
                  end
               end else if ((state_q == IFU_HOLD) && id_ready) begin
                  state_d = IFU_IDLE;
               end
            end
            IFU_REQ: begin
               if (mem_gnt) begin
                  state_d = IFU_WAIT;
               end
            end
            IFU_WAIT: begin
               if (mem_rvalid) begin
                  state_d    = IFU_HOLD;
                  instr_d    = select_word(mem_rdata, pc_q[2]);
                  misalign_d = 1'b0;
               end
            end
            IFU_DROP: begin
               if (mem_rvalid) begin
                  state_d = IFU_IDLE;
               end
            end
            default: state_d = IFU_IDLE;
         endcase
      end
   end

   // State registers. Reset drops any outstanding transaction outright since
   // the memory is reset alongside this unit.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IFU_IDLE;
         pc_q       <= '0;
         instr_q    <= '0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         misalign_q <= misalign_d;
      end
   end

endmodule

// File: tb/tb_ysyx_22040931_ifu.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22040931_ifu
// Bench for the fetch unit: a small instruction memory model with a
// programmable grant/response delay, directed fetch sequences, and a monitor
// that checks every decode handshake against a queue of expected fetches.
// ----------------------------------------------------------------------------
module tb_ysyx_22040931_ifu;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
      logic        misalign;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        flush;
   logic        pc_valid;
   logic [63:0] pc;
   logic        if_ready;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [63:0] mem_rdata;
   logic        id_valid;
   logic        id_ready;
   logic [63:0] id_pc;
   logic [31:0] id_instr;
   logic        id_misalign;

   bit          gnt_en;
   int          rvalid_delay;
   bit          fixed_mode;
   logic [63:0] fixed_data;
   bit          pend;
   int          pend_cnt;
   logic [63:0] pend_addr;

   exp_t        exp_q[$];
   int          checks   = 0;
   int          failures = 0;

   ysyx_22040931_ifu dut (
      .clock       (clock),
      .reset       (reset),
      .flush       (flush),
      .pc_valid    (pc_valid),
      .pc          (pc),
      .if_ready    (if_ready),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_gnt     (mem_gnt),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .id_valid    (id_valid),
      .id_ready    (id_ready),
      .id_pc       (id_pc),
      .id_instr    (id_instr),
      .id_misalign (id_misalign)
   );

   always #5 clock = ~clock;

   assign mem_gnt = mem_req & gnt_en;

   // Memory contents: the low word of each doubleword is addr+0x13 and the
   // high word addr+0x93, unless a fixed doubleword is selected.
   function automatic logic [63:0] mem_word(input logic [63:0] addr);
      if (fixed_mode) return fixed_data;
      return {addr[31:0] + 32'h93, addr[31:0] + 32'h13};
   endfunction

   function automatic logic [31:0] exp_instr(input logic [63:0] p);
      logic [31:0] base;
      base = {p[31:3], 3'b000};
      return p[2] ? base + 32'h93 : base + 32'h13;
   endfunction

   // Memory model: a granted request returns data rvalid_delay cycles after
   // the first possible response cycle (0 = response in the cycle after grant).
   always @(posedge clock) begin
      if (reset) begin
         mem_rvalid <= 1'b0;
         mem_rdata  <= '0;
         pend       <= 1'b0;
      end else begin
         mem_rvalid <= 1'b0;
         if (pend) begin
            if (pend_cnt == 0) begin
               mem_rvalid <= 1'b1;
               mem_rdata  <= mem_word(pend_addr);
               pend       <= 1'b0;
            end else begin
               pend_cnt <= pend_cnt - 1;
            end
         end
         if (mem_req && mem_gnt) begin
            if (rvalid_delay == 0) begin
               mem_rvalid <= 1'b1;
               mem_rdata  <= mem_word(mem_addr);
            end else begin
               pend      <= 1'b1;
               pend_cnt  <= rvalid_delay - 1;
               pend_addr <= mem_addr;
            end
         end
      end
   end

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input logic [63:0] p, input logic [31:0] i, input logic m);
      exp_t e;
      e.pc = p;
      e.instr = i;
      e.misalign = m;
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_id_valid(input string name, input int max);
      int n = 0;
      while (id_valid !== 1'b1 && n < max) begin
         step();
         n++;
      end
      if (id_valid !== 1'b1) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s: id_valid timeout after %0d cycles", name, max);
      end
   endtask

   task automatic wait_rvalid(input string name, input int max);
      int n = 0;
      while (mem_rvalid !== 1'b1 && n < max) begin
         step();
         n++;
      end
      if (mem_rvalid !== 1'b1) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s: mem_rvalid timeout after %0d cycles", name, max);
      end
   endtask

   // Monitor: every completed decode handshake must match the oldest
   // expected fetch; a handshake with nothing expected is itself an error.
   always @(negedge clock) begin
      if (reset === 1'b0 && id_valid === 1'b1 && id_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_id: got pc 0x%0h instr 0x%0h, required no instruction", id_pc, id_instr);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check_output("mon_id_pc", id_pc, e.pc);
            check_output("mon_id_instr", {32'h0, id_instr}, {32'h0, e.instr});
            check_output("mon_id_misalign", {63'h0, id_misalign}, {63'h0, e.misalign});
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit acc;
      int n;

      reset = 1'b1;
      flush = 1'b0;
      pc_valid = 1'b0;
      pc = '0;
      id_ready = 1'b1;
      gnt_en = 1'b1;
      rvalid_delay = 0;
      fixed_mode = 1'b0;
      fixed_data = '0;

      step();
      step();
      check_output("rst_if_ready", {63'h0, if_ready}, 64'h1);
      check_output("rst_mem_req", {63'h0, mem_req}, 64'h0);
      check_output("rst_mem_addr", mem_addr, 64'h0);
      check_output("rst_id_valid", {63'h0, id_valid}, 64'h0);
      check_output("rst_id_pc", id_pc, 64'h0);
      check_output("rst_id_instr", {32'h0, id_instr}, 64'h0);
      check_output("rst_id_misalign", {63'h0, id_misalign}, 64'h0);
      reset = 1'b0;
      step();

      $display("[TB] basic fetch, upper word");
      fixed_mode = 1'b1;
      fixed_data = 64'h00100093_00000013;
      pc = 64'h8000_0004;
      pc_valid = 1'b1;
      push_exp(64'h8000_0004, 32'h0010_0093, 1'b0);
      step();
      pc_valid = 1'b0;
      check_output("c1_mem_req", {63'h0, mem_req}, 64'h1);
      check_output("c1_mem_addr", mem_addr, 64'h8000_0000);
      check_output("c1_if_ready", {63'h0, if_ready}, 64'h0);
      check_output("c1_id_valid", {63'h0, id_valid}, 64'h0);
      step();
      check_output("c2_id_valid", {63'h0, id_valid}, 64'h0);
      check_output("c2_mem_req", {63'h0, mem_req}, 64'h0);
      step();
      check_output("c3_id_valid", {63'h0, id_valid}, 64'h1);
      step();
      fixed_mode = 1'b0;

      $display("[TB] decode stall then misaligned PC back-to-back");
      id_ready = 1'b0;
      pc = 64'h8000_0008;
      pc_valid = 1'b1;
      push_exp(64'h8000_0008, 32'h8000_001B, 1'b0);
      step();
      pc = 64'h8000_0002;
      push_exp(64'h8000_0002, 32'h0000_0013, 1'b1);
      wait_id_valid("stall_fetch", 10);
      for (int i = 0; i < 5; i++) begin
         check_output("stall_id_valid", {63'h0, id_valid}, 64'h1);
         check_output("stall_id_pc", id_pc, 64'h8000_0008);
         check_output("stall_id_instr", {32'h0, id_instr}, 64'h8000_001B);
         check_output("stall_if_ready", {63'h0, if_ready}, 64'h0);
         step();
      end
      id_ready = 1'b1;
      step();
      pc_valid = 1'b0;
      check_output("mis_mem_req", {63'h0, mem_req}, 64'h0);
      check_output("mis_id_valid", {63'h0, id_valid}, 64'h1);
      check_output("mis_id_misalign", {63'h0, id_misalign}, 64'h1);
      check_output("mis_id_instr", {32'h0, id_instr}, 64'h13);
      check_output("mis_id_pc", id_pc, 64'h8000_0002);
      step();
      check_output("mis_done_id_valid", {63'h0, id_valid}, 64'h0);

      $display("[TB] flush in WAIT, late response dropped");
      rvalid_delay = 3;
      fixed_mode = 1'b1;
      fixed_data = {32'hDEAD_BEEF, 32'hDEAD_BEEF};
      pc = 64'h8000_0010;
      pc_valid = 1'b1;
      step();
      pc_valid = 1'b0;
      step();
      check_output("wait_mem_req", {63'h0, mem_req}, 64'h0);
      flush = 1'b1;
      #1;
      check_output("flush_if_ready", {63'h0, if_ready}, 64'h0);
      step();
      flush = 1'b0;
      #1;
      check_output("drop_if_ready", {63'h0, if_ready}, 64'h0);
      check_output("drop_mem_req", {63'h0, mem_req}, 64'h0);
      wait_rvalid("drop_rvalid", 10);
      step();
      check_output("after_drop_if_ready", {63'h0, if_ready}, 64'h1);
      check_output("after_drop_id_valid", {63'h0, id_valid}, 64'h0);
      fixed_mode = 1'b0;
      rvalid_delay = 0;
      pc = 64'h8000_001C;
      pc_valid = 1'b1;
      push_exp(64'h8000_001C, 32'h8000_00AB, 1'b0);
      step();
      pc_valid = 1'b0;
      wait_id_valid("refetch", 10);
      step();

      $display("[TB] flush with grant in REQ");
      rvalid_delay = 1;
      pc = 64'h8000_0020;
      pc_valid = 1'b1;
      step();
      pc_valid = 1'b0;
      flush = 1'b1;
      #1;
      check_output("reqflush_mem_req", {63'h0, mem_req}, 64'h1);
      step();
      flush = 1'b0;
      #1;
      check_output("reqflush_drop_if_ready", {63'h0, if_ready}, 64'h0);
      step();
      check_output("reqflush_drop2_if_ready", {63'h0, if_ready}, 64'h0);
      step();
      check_output("reqflush_idle_if_ready", {63'h0, if_ready}, 64'h1);

      $display("[TB] flush with response in WAIT");
      rvalid_delay = 2;
      pc = 64'h8000_0028;
      pc_valid = 1'b1;
      step();
      pc_valid = 1'b0;
      step();
      wait_rvalid("waitflush_rvalid", 10);
      flush = 1'b1;
      step();
      flush = 1'b0;
      #1;
      check_output("waitflush_if_ready", {63'h0, if_ready}, 64'h1);
      check_output("waitflush_id_valid", {63'h0, id_valid}, 64'h0);
      step();
      check_output("waitflush_id_valid2", {63'h0, id_valid}, 64'h0);

      $display("[TB] streaming 8 sequential PCs");
      rvalid_delay = 0;
      id_ready = 1'b1;
      pc_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         pc = 64'h8000_0100 + 64'(4 * i);
         push_exp(pc, exp_instr(pc), 1'b0);
         n = 0;
         do begin
            acc = if_ready;
            step();
            n++;
         end while (!acc && n < 20);
         if (!acc) begin
            checks++;
            failures++;
            $display("[TB] FAIL stream_accept: pc 0x%0h not accepted within 20 cycles", pc);
         end
      end
      pc_valid = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         step();
         n++;
      end
      step();
      check_output("queue_empty", 64'(exp_q.size()), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ysyx_22040931_ifu.md
YSYX_22040931_IFU -- requirements
Module: ysyx_22040931_IFU

Interface
REQ-001 SHALL have port: clock  input  1  system clock; all state updates on posedge.
REQ-002 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: flush  input  1  pipeline redirect; kill current fetch.
REQ-004 SHALL have port: pc_valid  input  1  PC offered by PC stage.
REQ-005 SHALL have port: pc  input  64  PC value, sampled when pc_valid & if_ready.
REQ-006 SHALL have port: if_ready  output  1  IFU can accept a PC this cycle.
REQ-007 SHALL have port: mem_req  output  1  instruction memory read request.
REQ-008 SHALL have port: mem_addr  output  64  doubleword-aligned address, {pc_q[63:3],3'b000}.
REQ-009 SHALL have port: mem_gnt  input  1  memory accepted request this cycle.
REQ-010 SHALL have port: mem_rvalid  input  1  read data valid.
REQ-011 SHALL have port: mem_rdata  input  64  read data.
REQ-012 SHALL have port: id_valid  output  1  instruction offered to decode.
REQ-013 SHALL have port: id_ready  input  1  decode accepts instruction.
REQ-014 SHALL have port: id_pc  output  64  PC of offered instruction.
REQ-015 SHALL have port: id_instr  output  32  offered instruction.
REQ-016 SHALL have port: id_misalign  output  1  offered PC had pc[1:0]!=0.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, WAIT, HOLD, DROP.
REQ-018 SHALL drive if_ready = ~flush & (IDLE | (HOLD & id_ready)); if_ready low in REQ, WAIT, DROP.
REQ-019 SHALL, on pc_valid & if_ready, latch pc into pc_q; go REQ if pc[1:0]==0, else go HOLD with id_instr=32'h00000013, id_misalign=1, no memory request.
REQ-020 SHALL assert mem_req only in REQ (combinational from state, not from flush); REQ -> WAIT on mem_gnt.
REQ-021 SHALL, in WAIT on mem_rvalid, latch id_instr = pc_q[2] ? mem_rdata[63:32] : mem_rdata[31:0], id_misalign=0, go HOLD; data visible on id_instr the next cycle (min latency pc accept -> id_valid = 3 cycles with 0-wait gnt/rvalid).
REQ-022 SHALL drive id_valid = HOLD & ~flush; id_pc = pc_q.
REQ-023 SHALL, in HOLD on id_ready: go REQ/HOLD per REQ-019 if pc_valid, else IDLE (back-to-back throughput allowed).
REQ-024 SHALL hold id_pc, id_instr, id_misalign stable while id_valid & ~id_ready.
REQ-025 SHALL on flush: IDLE/HOLD -> IDLE; REQ -> IDLE if ~mem_gnt, DROP if mem_gnt; WAIT -> IDLE if mem_rvalid, DROP otherwise; DROP unchanged.
REQ-026 SHALL in DROP discard data and go IDLE on mem_rvalid; no PC accepted in DROP.
REQ-027 SHALL ignore mem_rvalid in IDLE, REQ, HOLD.
REQ-028 SHALL give flush priority over pc_valid and id_ready in the same cycle.

Reset
REQ-029 SHALL on reset enter IDLE, pc_q=0, id_instr=0, id_misalign=0; outputs then if_ready=1, mem_req=0, mem_addr=0, id_valid=0, id_pc=0.
REQ-030 SHALL abandon any outstanding memory transaction on reset without entering DROP (memory reset concurrently).

Structure
REQ-031 SHALL take PC width, instruction width, NOP constant and state encodings from the shared defines file (ysyx_22040931_PC_BUS, ysyx_22040931_INST_BUS).
REQ-032 SHALL be one module; no sub-modules.

Verification
REQ-033 Reset then pc_valid=1, pc=0x80000004, gnt/rvalid immediate, rdata=0x00100093_00000013, id_ready=1 -> id_valid cycle 3, id_instr=0x00100093, id_pc=0x80000004.
REQ-034 id_ready=0 for 5 cycles in HOLD -> id_valid, id_pc, id_instr stable; if_ready=0 throughout.
REQ-035 pc=0x80000002 -> no mem_req, next cycle id_valid=1, id_misalign=1, id_instr=0x00000013.
REQ-036 flush in WAIT, rvalid 3 cycles later with 0xDEADBEEF -> DROP, id_valid never 1, if_ready=1 after rvalid, next PC fetched normally.
REQ-037 flush coincident with mem_gnt in REQ -> DROP; flush coincident with mem_rvalid in WAIT -> IDLE, data discarded.
REQ-038 Continuous pc_valid, id_ready=1, 0-wait memory, 8 sequential PCs -> 8 instructions in order, matching id_pc, none lost or duplicated.
